// File: rtl/ec_fp_mult_arb_pkg.sv
// Shared definitions for the Fp multiplier arbiter: multiplier ctl layout and response classification.
package ec_fp_mult_arb_pkg;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_DAT_BITS = 381;
  localparam int DEF_CTL_BITS = 8;
  localparam int DEF_OUT_MAX  = 16;

  // Multiplier ctl is {tag, requester ctl}; the multiplier echoes it back unmodified,
  // so the tag always sits directly above the requester's ctl bits.
  function automatic int tag_lsb(input int ctl_bits);
    return ctl_bits;
  endfunction

  function automatic int mul_ctl_bits(input int num_req, input int ctl_bits);
    return $clog2(num_req) + ctl_bits;
  endfunction

  typedef enum logic [1:0] {
    RES_FWD     = 2'd0,
    RES_BAD_TAG = 2'd1,
    RES_NO_OUT  = 2'd2
  } res_kind_e;

endpackage

// File: rtl/ec_fp_mult_arb_rr_arb.sv
// Round-robin arbiter: searches upward from the pointer, grants one requester when enabled.
module ec_fp_mult_arb_rr_arb #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] ptr_q;
  logic          found;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    int k;
    k         = 0;
    found     = 1'b0;
    o_gnt_idx = '0;
    o_gnt     = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr_q) + i;
      if (k >= N) k = k - N;
      if (!found && i_req[k]) begin
        found     = 1'b1;
        o_gnt_idx = IW'(k);
      end
    end
    if (i_en && found) o_gnt[o_gnt_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else if (i_en && found) begin
      ptr_q <= (int'(o_gnt_idx) == N - 1) ? '0 : o_gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/ec_fp_mult_arb.sv
// Shares one pipelined Fp multiplier between NUM_REQ engines: RR issue, tag-routed responses,
// per-requester outstanding limits and a sticky error for unexpected results.
module ec_fp_mult_arb
  import ec_fp_mult_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int DAT_BITS = DEF_DAT_BITS,
  parameter int CTL_BITS = DEF_CTL_BITS,
  parameter int OUT_MAX  = DEF_OUT_MAX,
  localparam int TAG_BITS  = $clog2(NUM_REQ),
  localparam int MCTL_BITS = mul_ctl_bits(NUM_REQ, CTL_BITS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ*2*DAT_BITS-1:0]  i_req_dat,
  input  logic [NUM_REQ*CTL_BITS-1:0]    i_req_ctl,
  input  logic [NUM_REQ-1:0]             i_req_val,
  output logic [NUM_REQ-1:0]             o_req_rdy,
  output logic [2*DAT_BITS-1:0]          o_mul_dat,
  output logic [MCTL_BITS-1:0]           o_mul_ctl,
  output logic                           o_mul_val,
  input  logic                           i_mul_rdy,
  input  logic [DAT_BITS-1:0]            i_res_dat,
  input  logic [MCTL_BITS-1:0]           i_res_ctl,
  input  logic                           i_res_val,
  output logic                           o_res_rdy,
  output logic [NUM_REQ*DAT_BITS-1:0]    o_rsp_dat,
  output logic [NUM_REQ*CTL_BITS-1:0]    o_rsp_ctl,
  output logic [NUM_REQ-1:0]             o_rsp_val,
  input  logic [NUM_REQ-1:0]             i_rsp_rdy,
  output logic                           o_err
);

  localparam int CNT_BITS = $clog2(OUT_MAX + 1);
  localparam int TAG_LSB  = tag_lsb(CTL_BITS);

  logic                slot_free;
  logic                arb_en;
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  gnt;
  logic [TAG_BITS-1:0] gnt_idx;
  logic [TAG_BITS-1:0] res_tag;
  res_kind_e           res_kind;
  logic                res_acc;
  logic [NUM_REQ-1:0]  rsp_free;
  logic [NUM_REQ-1:0]  deliver;
  logic [CNT_BITS-1:0] cnt_q [NUM_REQ];

  // Readies are held low while reset is asserted so nothing handshakes into a clearing pipeline.
  always_comb begin
    slot_free = ~o_mul_val | i_mul_rdy;
    arb_en    = slot_free & i_rst_n;
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = i_req_val[k] & (cnt_q[k] < CNT_BITS'(OUT_MAX));
    end
  end

  ec_fp_mult_arb_rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_req     (eligible),
    .i_en      (arb_en),
    .o_gnt     (gnt),
    .o_gnt_idx (gnt_idx)
  );

  assign o_req_rdy = gnt;

  // Unknown tags are always drained; known tags wait for that requester's output register.
  always_comb begin
    res_tag   = i_res_ctl[TAG_LSB +: TAG_BITS];
    rsp_free  = ~o_rsp_val | i_rsp_rdy;
    res_kind  = RES_BAD_TAG;
    o_res_rdy = i_rst_n;
    deliver   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (res_tag == TAG_BITS'(k)) begin
        res_kind  = (cnt_q[k] == '0) ? RES_NO_OUT : RES_FWD;
        o_res_rdy = i_rst_n & rsp_free[k];
      end
    end
    res_acc = i_res_val & o_res_rdy;
    for (int k = 0; k < NUM_REQ; k++) begin
      deliver[k] = res_acc && (res_kind == RES_FWD) && (res_tag == TAG_BITS'(k));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mul_val <= 1'b0;
      o_mul_dat <= '0;
      o_mul_ctl <= '0;
    end else if (|gnt) begin
      o_mul_val <= 1'b1;
      o_mul_dat <= i_req_dat[int'(gnt_idx)*2*DAT_BITS +: 2*DAT_BITS];
      o_mul_ctl <= {gnt_idx, i_req_ctl[int'(gnt_idx)*CTL_BITS +: CTL_BITS]};
    end else if (i_mul_rdy) begin
      o_mul_val <= 1'b0;
    end
  end

  // NOTE: the counter array is reset element by element; reset discards every in-flight operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        case ({gnt[k], deliver[k]})
          2'b10:   cnt_q[k] <= cnt_q[k] + 1'b1;
          2'b01:   cnt_q[k] <= cnt_q[k] - 1'b1;
          default: cnt_q[k] <= cnt_q[k];
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rsp_val <= '0;
      o_rsp_dat <= '0;
      o_rsp_ctl <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (deliver[k]) begin
          o_rsp_val[k]                          <= 1'b1;
          o_rsp_dat[k*DAT_BITS +: DAT_BITS]     <= i_res_dat;
          o_rsp_ctl[k*CTL_BITS +: CTL_BITS]     <= i_res_ctl[CTL_BITS-1:0];
        end else if (i_rsp_rdy[k]) begin
          o_rsp_val[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if (res_acc && (res_kind != RES_FWD)) begin
      o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ec_fp_mult_arb.sv
// Directed bench for ec_fp_mult_arb with an issue/response scoreboard and a bench-side multiplier model.
module tb_ec_fp_mult_arb;

  localparam int NUM_REQ  = 3;
  localparam int DAT_BITS = 381;
  localparam int CTL_BITS = 8;
  localparam int OUT_MAX  = 16;
  localparam int TAG_BITS = $clog2(NUM_REQ);
  localparam int MCTL     = TAG_BITS + CTL_BITS;
  localparam int WW       = 2 * DAT_BITS;
  localparam int BOUND    = 64;

  typedef logic [DAT_BITS-1:0] dat_t;
  typedef logic [CTL_BITS-1:0] ctl_t;
  typedef logic [MCTL-1:0]     mctl_t;
  typedef struct { int k; ctl_t ctl; dat_t a; dat_t b; } iss_t;
  typedef struct { int k; dat_t dat; ctl_t ctl; } exp_t;
  typedef struct { dat_t dat; mctl_t ctl; } ret_t;

  logic                          clk = 1'b0;
  logic                          i_rst_n;
  logic [NUM_REQ*WW-1:0]         i_req_dat;
  logic [NUM_REQ*CTL_BITS-1:0]   i_req_ctl;
  logic [NUM_REQ-1:0]            i_req_val;
  logic [NUM_REQ-1:0]            o_req_rdy;
  logic [WW-1:0]                 o_mul_dat;
  logic [MCTL-1:0]               o_mul_ctl;
  logic                          o_mul_val;
  logic                          i_mul_rdy;
  logic [DAT_BITS-1:0]           i_res_dat;
  logic [MCTL-1:0]               i_res_ctl;
  logic                          i_res_val;
  logic                          o_res_rdy;
  logic [NUM_REQ*DAT_BITS-1:0]   o_rsp_dat;
  logic [NUM_REQ*CTL_BITS-1:0]   o_rsp_ctl;
  logic [NUM_REQ-1:0]            o_rsp_val;
  logic [NUM_REQ-1:0]            i_rsp_rdy;
  logic                          o_err;

  dat_t req_a [NUM_REQ];
  dat_t req_b [NUM_REQ];
  ctl_t req_c [NUM_REQ];

  iss_t iss_q[$];
  exp_t exp_q[$];
  ret_t mul_pipe[$];
  int   gnt_hist[$];
  int   model_cnt [NUM_REQ];
  logic model_err = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ec_fp_mult_arb #(
    .NUM_REQ(NUM_REQ), .DAT_BITS(DAT_BITS), .CTL_BITS(CTL_BITS), .OUT_MAX(OUT_MAX)
  ) u_dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_req_dat(i_req_dat), .i_req_ctl(i_req_ctl), .i_req_val(i_req_val), .o_req_rdy(o_req_rdy),
    .o_mul_dat(o_mul_dat), .o_mul_ctl(o_mul_ctl), .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy),
    .i_res_dat(i_res_dat), .i_res_ctl(i_res_ctl), .i_res_val(i_res_val), .o_res_rdy(o_res_rdy),
    .o_rsp_dat(o_rsp_dat), .o_rsp_ctl(o_rsp_ctl), .o_rsp_val(o_rsp_val), .i_rsp_rdy(i_rsp_rdy),
    .o_err(o_err)
  );

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      i_req_dat[k*WW +: WW]             = {req_b[k], req_a[k]};
      i_req_ctl[k*CTL_BITS +: CTL_BITS] = req_c[k];
    end
  end

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic mctl_t mk_ctl(input int k, input ctl_t c);
    return {TAG_BITS'(k), c};
  endfunction

  function automatic dat_t rsp_dat(input int k);
    return o_rsp_dat[k*DAT_BITS +: DAT_BITS];
  endfunction

  function automatic ctl_t rsp_ctl(input int k);
    return o_rsp_ctl[k*CTL_BITS +: CTL_BITS];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    iss_q.delete();
    exp_q.delete();
    mul_pipe.delete();
    gnt_hist.delete();
    for (int k = 0; k < NUM_REQ; k++) model_cnt[k] = 0;
    model_err = 1'b0;
  endtask

  // Holds one request valid until granted, then drops it right after the granting edge.
  task automatic issue(input int k, input dat_t a, input dat_t b, input ctl_t c);
    int n;
    n = 0;
    req_a[k] = a; req_b[k] = b; req_c[k] = c;
    i_req_val[k] = 1'b1;
    @(negedge clk);
    while (!o_req_rdy[k] && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", WW'(n < BOUND), WW'(1));
    tick();
    i_req_val[k] = 1'b0;
  endtask

  task automatic drive_res(input dat_t d, input mctl_t c);
    int n;
    n = 0;
    i_res_dat = d; i_res_ctl = c; i_res_val = 1'b1;
    @(negedge clk);
    while (!o_res_rdy && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    check("res_wait", WW'(n < BOUND), WW'(1));
    tick();
    i_res_val = 1'b0;
  endtask

  task automatic ret_idx(input int i);
    ret_t r;
    r = mul_pipe[i];
    mul_pipe.delete(i);
    drive_res(r.dat, r.ctl);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mul_pipe.size() > 0 && guard < 4 * BOUND) begin
      ret_idx(0);
      guard++;
    end
    check("drain_done", WW'(mul_pipe.size()), WW'(0));
    tick(2);
  endtask

  // Scoreboard: compares counters/error against the model, then records the handshakes of the coming edge.
  always @(negedge clk) begin : mon
    iss_t e;
    exp_t x;
    ret_t r;
    dat_t p;
    int   t;
    int   idx;
    if (i_rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) check("cnt", WW'(u_dut.cnt_q[k]), WW'(model_cnt[k]));
      check("err", WW'(o_err), WW'(model_err));
      check("rdy_onehot", WW'($countones(o_req_rdy) <= 1), WW'(1));
      for (int k = 0; k < NUM_REQ; k++) begin
        if (i_req_val[k] && o_req_rdy[k]) begin
          e.k = k; e.ctl = req_c[k]; e.a = req_a[k]; e.b = req_b[k];
          iss_q.push_back(e);
          p = req_a[k] * req_b[k];
          x.k = k; x.dat = p; x.ctl = req_c[k];
          exp_q.push_back(x);
          model_cnt[k]++;
          gnt_hist.push_back(k);
        end
      end
      if (o_mul_val && i_mul_rdy) begin
        if (iss_q.size() == 0) begin
          check("mul_unexpected", WW'(1), WW'(0));
        end else begin
          e = iss_q.pop_front();
          check("mul_ctl", WW'(o_mul_ctl), WW'(mk_ctl(e.k, e.ctl)));
          check("mul_dat", o_mul_dat, {e.b, e.a});
        end
        p = o_mul_dat[DAT_BITS-1:0] * o_mul_dat[WW-1:DAT_BITS];
        r.dat = p; r.ctl = o_mul_ctl;
        mul_pipe.push_back(r);
      end
      if (i_res_val && o_res_rdy) begin
        t = int'(i_res_ctl[MCTL-1 -: TAG_BITS]);
        if (t < NUM_REQ && model_cnt[t] > 0) model_cnt[t]--;
        else model_err = 1'b1;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (o_rsp_val[k] && i_rsp_rdy[k]) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].k == k) idx = i;
          end
          if (idx < 0) begin
            check("rsp_unexpected", WW'(k + 1), WW'(0));
          end else begin
            x = exp_q[idx];
            exp_q.delete(idx);
            check("rsp_dat", WW'(rsp_dat(k)), WW'(x.dat));
            check("rsp_ctl", WW'(rsp_ctl(k)), WW'(x.ctl));
          end
        end
      end
    end
  end

  initial begin
    i_rst_n = 1'b0;
    i_req_val = '0;
    i_mul_rdy = 1'b1;
    i_res_dat = '0;
    i_res_ctl = '0;
    i_res_val = 1'b0;
    i_rsp_rdy = '1;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_a[k] = '0; req_b[k] = '0; req_c[k] = '0;
    end
    clear_model();

    // Reset state, with requests and a bad-tag result pending to prove readies are gated.
    i_req_val = 3'b011;
    i_res_ctl = mk_ctl(3, 8'h00);
    i_res_val = 1'b1;
    tick(2);
    check("rst_mul_val", WW'(o_mul_val), WW'(0));
    check("rst_rsp_val", WW'(o_rsp_val), WW'(0));
    check("rst_req_rdy", WW'(o_req_rdy), WW'(0));
    check("rst_res_rdy", WW'(o_res_rdy), WW'(0));
    check("rst_err", WW'(o_err), WW'(0));
    check("rst_mul_dat", o_mul_dat, WW'(0));
    check("rst_rsp_dat", WW'(o_rsp_dat), WW'(0));
    i_req_val = '0;
    i_res_val = 1'b0;
    i_res_ctl = '0;
    i_rst_n = 1'b1;
    tick(2);

    // Single request: 3*5 with ctl 0x07, tagged 0, plus a multiplier stall.
    issue(0, 3, 5, 8'h07);
    i_mul_rdy = 1'b0;
    check("t1_mul_val", WW'(o_mul_val), WW'(1));
    check("t1_mul_ctl", WW'(o_mul_ctl), WW'(mk_ctl(0, 8'h07)));
    req_a[1] = 2; req_b[1] = 2; req_c[1] = 8'h0f;
    i_req_val[1] = 1'b1;
    @(negedge clk);
    check("t1_stall_rdy", WW'(o_req_rdy), WW'(0));
    tick();
    check("t1_stall_hold", WW'(o_mul_ctl), WW'(mk_ctl(0, 8'h07)));
    i_req_val[1] = 1'b0;
    i_mul_rdy = 1'b1;
    tick(4);
    ret_idx(0);
    check("t1_rsp_val", WW'(o_rsp_val[0]), WW'(1));
    check("t1_rsp_dat", WW'(rsp_dat(0)), WW'(15));
    check("t1_rsp_ctl", WW'(rsp_ctl(0)), WW'(8'h07));
    tick();
    check("t1_cnt0", WW'(u_dut.cnt_q[0]), WW'(0));

    // Two requesters streaming: grants alternate, one per cycle.
    gnt_hist.delete();
    for (int k = 0; k < 2; k++) begin
      req_a[k] = dat_t'(k + 2); req_b[k] = dat_t'(7 + k); req_c[k] = ctl_t'(8'h10 + k);
    end
    i_req_val = 3'b011;
    tick(8);
    i_req_val = '0;
    check("t2_grants", WW'(gnt_hist.size()), WW'(8));
    for (int i = 1; i < gnt_hist.size(); i++) begin
      check("t2_alternate", WW'(gnt_hist[i]), WW'(1 - gnt_hist[i-1]));
    end
    tick();
    drain();

    // Outstanding limit on requester 1; requester 0 unaffected.
    for (int i = 0; i < OUT_MAX; i++) issue(1, dat_t'(i + 1), 3, ctl_t'(8'h20 + i));
    req_a[1] = 99; req_b[1] = 2; req_c[1] = 8'h30;
    req_a[0] = 4; req_b[0] = 6; req_c[0] = 8'h31;
    i_req_val = 3'b011;
    @(negedge clk);
    check("t3_full_rdy1", WW'(o_req_rdy[1]), WW'(0));
    check("t3_rdy0", WW'(o_req_rdy[0]), WW'(1));
    tick();
    i_req_val[0] = 1'b0;
    @(negedge clk);
    check("t3_still_full", WW'(o_req_rdy[1]), WW'(0));
    tick();
    ret_idx(0);
    @(negedge clk);
    check("t3_reenabled", WW'(o_req_rdy[1]), WW'(1));
    tick();
    i_req_val[1] = 1'b0;
    drain();

    // Response back-pressure on requester 0, with a tag-1 result slipping through.
    issue(0, 11, 13, 8'h41);
    issue(0, 17, 19, 8'h42);
    issue(1, 23, 29, 8'h43);
    tick(2);
    i_rsp_rdy[0] = 1'b0;
    ret_idx(0);
    i_res_dat = mul_pipe[0].dat; i_res_ctl = mul_pipe[0].ctl; i_res_val = 1'b1;
    @(negedge clk);
    check("t4_stall_a", WW'(o_res_rdy), WW'(0));
    tick();
    @(negedge clk);
    check("t4_stall_b", WW'(o_res_rdy), WW'(0));
    tick();
    i_res_dat = mul_pipe[1].dat; i_res_ctl = mul_pipe[1].ctl;
    @(negedge clk);
    check("t4_tag1_rdy", WW'(o_res_rdy), WW'(1));
    tick();
    mul_pipe.delete(1);
    check("t4_tag1_val", WW'(o_rsp_val[1]), WW'(1));
    i_res_dat = mul_pipe[0].dat; i_res_ctl = mul_pipe[0].ctl;
    @(negedge clk);
    check("t4_stall_c", WW'(o_res_rdy), WW'(0));
    tick();
    i_rsp_rdy[0] = 1'b1;
    @(negedge clk);
    check("t4_release", WW'(o_res_rdy), WW'(1));
    tick();
    i_res_val = 1'b0;
    mul_pipe.delete(0);
    check("t4_second_dat", WW'(rsp_dat(0)), WW'(17 * 19));
    tick(2);

    // Unexpected results: tag 0 with nothing outstanding, then an out-of-range tag.
    drive_res(dat_t'(16'hdead), mk_ctl(0, 8'h55));
    check("t5_err", WW'(o_err), WW'(1));
    check("t5_no_rsp", WW'(o_rsp_val), WW'(0));
    i_rsp_rdy = '0;
    i_res_dat = dat_t'(16'hbeef); i_res_ctl = mk_ctl(NUM_REQ, 8'h66); i_res_val = 1'b1;
    @(negedge clk);
    check("t5_badtag_rdy", WW'(o_res_rdy), WW'(1));
    tick();
    i_res_val = 1'b0;
    tick(3);
    check("t5_err_sticky", WW'(o_err), WW'(1));
    check("t5_no_rsp2", WW'(o_rsp_val), WW'(0));
    for (int k = 0; k < NUM_REQ; k++) check("t5_cnt", WW'(u_dut.cnt_q[k]), WW'(0));
    i_rsp_rdy = '1;

    // Asynchronous reset with five operations in flight.
    issue(0, 2, 3, 8'h51);
    issue(1, 4, 5, 8'h52);
    issue(0, 6, 7, 8'h53);
    issue(2, 8, 9, 8'h54);
    issue(1, 10, 11, 8'h55);
    check("t6_cnt1", WW'(u_dut.cnt_q[1]), WW'(2));
    i_req_val = 3'b011;
    #3;
    i_rst_n = 1'b0;
    clear_model();
    #1;
    check("t6_mul_val", WW'(o_mul_val), WW'(0));
    check("t6_rsp_val", WW'(o_rsp_val), WW'(0));
    check("t6_req_rdy", WW'(o_req_rdy), WW'(0));
    check("t6_res_rdy", WW'(o_res_rdy), WW'(0));
    check("t6_err", WW'(o_err), WW'(0));
    for (int k = 0; k < NUM_REQ; k++) check("t6_cnt", WW'(u_dut.cnt_q[k]), WW'(0));
    i_req_val = '0;
    tick(2);
    i_rst_n = 1'b1;
    tick();
    issue(2, 9, 9, 8'h99);
    tick(3);
    ret_idx(0);
    check("t6_resume_val", WW'(o_rsp_val[2]), WW'(1));
    check("t6_resume_dat", WW'(rsp_dat(2)), WW'(81));
    check("t6_resume_ctl", WW'(rsp_ctl(2)), WW'(8'h99));
    tick(2);

    check("end_iss_q", WW'(iss_q.size()), WW'(0));
    check("end_exp_q", WW'(exp_q.size()), WW'(0));
    check("end_mul_pipe", WW'(mul_pipe.size()), WW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ec_fp_mult_arb.md
Name: ec_fp_mult_arb

Overview:
- Shares one pipelined Fp modular multiplier between NUM_REQ point-arithmetic engines, e.g. point doubling and point addition engines.
- Round-robin arbitrates multiply requests.
- Tags each request's ctl with the requester index.
- Demultiplexes returning results to the issuing requester by tag.
- Tracks outstanding operations per requester.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- DAT_BITS, 381, operand/result width.
- CTL_BITS, 8, requester-side ctl width, passed through untouched.
- TAG_BITS, $clog2(NUM_REQ), derived; tag width prepended to ctl.
- OUT_MAX, 16, max outstanding multiplies per requester.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_dat  in  NUM_REQ×2·DAT_BITS  operands per requester; a in [0+:DAT_BITS], b in [DAT_BITS+:DAT_BITS].
- i_req_ctl  in  NUM_REQ×CTL_BITS  requester tag/equation id.
- i_req_val  in  NUM_REQ  request valid.
- o_req_rdy  out  NUM_REQ  request accepted when val&rdy.
- o_mul_dat  out  2·DAT_BITS  operands to multiplier.
- o_mul_ctl  out  TAG_BITS+CTL_BITS  {tag, ctl}.
- o_mul_val  out  1.
- i_mul_rdy  in  1.
- i_res_dat  in  DAT_BITS  multiplier result.
- i_res_ctl  in  TAG_BITS+CTL_BITS  echoed {tag, ctl}.
- i_res_val  in  1.
- o_res_rdy  out  1.
- o_rsp_dat  out  NUM_REQ×DAT_BITS  result to each requester.
- o_rsp_ctl  out  NUM_REQ×CTL_BITS  original ctl.
- o_rsp_val  out  NUM_REQ.
- i_rsp_rdy  in  NUM_REQ.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset (async, i_rst_n=0):
  - All *_val=0, o_req_rdy=0, o_res_rdy=0, o_err=0.
  - Data/ctl outputs 0, RR pointer=0, outstanding counters=0.
  - Reset mid-operation discards everything in flight; requesters restart.
- Request path (single output register):
  - slot_free = ~o_mul_val | i_mul_rdy.
  - Eligible k: i_req_val[k] & cnt[k]<OUT_MAX.
  - Winner = first eligible k searching from pointer upward, wrapping modulo NUM_REQ.
  - o_req_rdy[k] = slot_free & (k==winner); combinational. At most one bit is high.
  - On grant:
    - Next cycle o_mul_val=1, o_mul_dat=i_req_dat[k], o_mul_ctl={k, i_req_ctl[k]}.
    - Pointer ← (k+1) mod NUM_REQ.
  - No grant: pointer holds. o_mul_val clears when accepted with no new grant.
  - Latency request→multiplier is 1 cycle. Full throughput of 1 per cycle.
- Response path (per-requester output register):
  - t = i_res_ctl[top TAG_BITS].
  - o_res_rdy = (t<NUM_REQ) ? (~o_rsp_val[t] | i_rsp_rdy[t]) : 1. Invalid tags are always drained.
  - On accept with valid t and cnt[t]>0:
    - Next cycle o_rsp_val[t]=1, o_rsp_dat[t]=i_res_dat, o_rsp_ctl[t]=low CTL_BITS.
  - o_rsp_val[k] clears on i_rsp_rdy[k] with no new result for k.
  - Latency multiplier→requester is 1 cycle.
- Counters:
  - +1 on grant, −1 on response accept for that tag.
  - Both in the same cycle leaves the count unchanged.
  - Never exceed OUT_MAX, because a requester at OUT_MAX is ineligible.
- Errors:
  - A response with t≥NUM_REQ, or with cnt[t]==0, is accepted and dropped.
  - That response is not forwarded and does not change any counter.
  - o_err←1 and stays set until reset.
- Ordering:
  - Responses per requester are forwarded in multiplier return order.
  - Cross-requester interleaving is unconstrained.

Decomposition:
- Shared ec package holds:
  - the tag/ctl concatenation layout helper;
  - the rule that the multiplier echoes ctl unmodified.
- Sub-module rr_arb:
  - parameter N;
  - inputs req[N], en (=slot_free), pointer update on grant;
  - outputs one-hot gnt[N] and gnt_idx.
  - Reusable for the adder and subtractor arbiters.

Test Plan:
- Single requester 0 issues a=3, b=5, ctl=0x07; multiplier model returns 15 after 4 cycles.
  - Expect o_mul_ctl={0,0x07} 1 cycle after grant.
  - Expect o_rsp_dat[0]=15, o_rsp_ctl[0]=0x07; cnt[0] back to 0.
- Both requesters hold val continuously, with i_mul_rdy=1.
  - Expect grants alternate 0,1,0,1.
  - Expect 8 grants in 8 cycles and each requester's results routed only to itself.
- Requester 1 issues 16 requests with the multiplier returning none.
  - Expect o_req_rdy[1]=0 on the 17th.
  - Requester 0 still granted.
  - One result for tag 1 re-enables requester 1 the next cycle.
- i_rsp_rdy[0]=0 with two results for tag 0 back-to-back.
  - Expect o_res_rdy=0 on the second until i_rsp_rdy[0]=1.
  - No data lost; a result for tag 1 in the stalled cycle is still accepted.
- Inject a result with tag 0 and cnt[0]=0, then tag=NUM_REQ.
  - Expect o_err=1 sticky, no o_rsp_val pulse, counters unchanged.
- Assert i_rst_n=0 mid-burst with 5 outstanding.
  - Expect all val=0 and counters 0 immediately (async).
  - Normal operation resumes after release.
